cnn_layer_accel_conv_seq_ctrl: RTL and testbench

// - Sequencer in front of cnn_layer_accel_layer_conv_array: on start, pulses count_init, loads C_MAX_WINDOW_SIZE filter beats, streams cfg_num_pix image beats, then drains.
// - Converts upstream valid/ready filter and image streams into the array's init/valid strobes.
// - Signals completion once cfg_num_out array results have been observed.

---
 rtl/cnn_layer_accel_conv_seq_ctrl_pkg.sv | 26 ++
 rtl/cnn_layer_accel_conv_seq_ctrl_if.sv | 39 +++
 rtl/cnn_layer_accel_conv_seq_ctrl_counter.sv | 37 +++
 rtl/cnn_layer_accel_conv_seq_ctrl.sv | 154 +++++++++++++++
 tb/tb_cnn_layer_accel_conv_seq_ctrl.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/cnn_layer_accel_conv_seq_ctrl_pkg.sv
// Shared types and sizes for the conv-array sequencer.
// Optional perf counters are enabled with CNN_SEQ_PERF_CNT_EN.
package cnn_layer_accel_seq_pkg;

  localparam int unsigned C_MAX_WINDOW_SIZE   = 3;
  localparam int unsigned C_IMG_DATA_WIDTH    = 18;
  localparam int unsigned C_FILTER_DATA_WIDTH = 18;
  localparam int unsigned C_CNT_WIDTH         = 16;

  localparam int unsigned C_FILT_BUS_W = C_MAX_WINDOW_SIZE * C_FILTER_DATA_WIDTH;
  localparam int unsigned C_IMG_BUS_W  = C_MAX_WINDOW_SIZE * C_IMG_DATA_WIDTH;

  // One filter beat per window row; the beat counter wraps after the last lane.
  localparam int unsigned C_FBEAT_W    = $clog2(C_MAX_WINDOW_SIZE + 1);
  localparam int unsigned C_LAST_FBEAT = C_MAX_WINDOW_SIZE - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CINIT,
    S_FLOAD,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } seq_state_e;

endpackage

// File: rtl/cnn_layer_accel_conv_seq_ctrl_if.sv
// Control, stream and array-side signals of the conv-array sequencer.
interface cnn_layer_accel_conv_seq_ctrl_if;
  import cnn_layer_accel_seq_pkg::*;

  logic                    start;
  logic                    abort;
  logic [C_CNT_WIDTH-1:0]  cfg_num_pix;
  logic [C_CNT_WIDTH-1:0]  cfg_num_out;
  logic                    filt_valid;
  logic                    filt_ready;
  logic [C_FILT_BUS_W-1:0] filt_data;
  logic                    img_valid;
  logic                    img_ready;
  logic [C_IMG_BUS_W-1:0]  img_data;
  logic                         count_init;
  logic                         pipeline_active;
  logic [C_MAX_WINDOW_SIZE-1:0] i_filter_init;
  logic [C_FILT_BUS_W-1:0]      i_filter_datain;
  logic [C_IMG_BUS_W-1:0]       i_img_datain;
  logic                         img_datain_valid;
  logic                         arr_dataout_valid;
  logic                         busy;
  logic                         done;

  modport master (
    output start, abort, cfg_num_pix, cfg_num_out,
    output filt_valid, filt_data, img_valid, img_data, arr_dataout_valid,
    input  filt_ready, img_ready, count_init, pipeline_active, i_filter_init,
    input  i_filter_datain, i_img_datain, img_datain_valid, busy, done
  );

  modport slave (
    input  start, abort, cfg_num_pix, cfg_num_out,
    input  filt_valid, filt_data, img_valid, img_data, arr_dataout_valid,
    output filt_ready, img_ready, count_init, pipeline_active, i_filter_init,
    output i_filter_datain, i_img_datain, img_datain_valid, busy, done
  );

endinterface

// File: rtl/cnn_layer_accel_conv_seq_ctrl_counter.sv
// Loadable up/down counter that saturates at zero (down) or all-ones (up).
module cnn_layer_accel_seq_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  input  logic         up_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      if (up_i) begin
        if (cnt_q != '1) cnt_d = cnt_q + W'(1);
      end else begin
        if (cnt_q != '0) cnt_d = cnt_q - W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/cnn_layer_accel_conv_seq_ctrl.sv
// Sequencer feeding cnn_layer_accel_layer_conv_array: count init, filter load, image stream, drain.
// Define CNN_SEQ_PERF_CNT_EN to add the stall/total cycle counters.
module cnn_layer_accel_conv_seq_ctrl
  import cnn_layer_accel_seq_pkg::*;
(
  input  logic clk,
  input  logic rst,
  cnn_layer_accel_conv_seq_ctrl_if.slave bus
`ifdef CNN_SEQ_PERF_CNT_EN
  ,
  output logic [C_CNT_WIDTH-1:0] perf_stall_cycles,
  output logic [C_CNT_WIDTH-1:0] perf_total_cycles
`endif
);

  seq_state_e state_q, state_d;

  logic [C_FBEAT_W-1:0]         fbeat_q;
  logic [C_CNT_WIDTH-1:0]       cfg_out_q;
  logic [C_CNT_WIDTH-1:0]       pix_cnt;
  logic [C_CNT_WIDTH-1:0]       out_cnt;
  logic                         count_init_q;
  logic                         pipe_q;
  logic                         busy_q;
  logic                         done_q;
  logic [C_MAX_WINDOW_SIZE-1:0] finit_q;
  logic [C_FILT_BUS_W-1:0]      fdata_q;
  logic [C_IMG_BUS_W-1:0]       idata_q;
  logic                         ivld_q;

  logic filt_rdy, img_rdy;
  logic start_go, filt_acc, img_acc, run_win, arr_inc, out_reached, last_fbeat;

  assign filt_rdy = (state_q == S_FLOAD);
  assign img_rdy  = (state_q == S_STREAM) && (pix_cnt != '0);

  // Beats arriving in the abort cycle are dropped.
  assign start_go   = (state_q == S_IDLE) && bus.start;
  assign filt_acc   = bus.filt_valid && filt_rdy && !bus.abort;
  assign img_acc    = bus.img_valid && img_rdy && !bus.abort;
  assign run_win    = state_q inside {S_CINIT, S_FLOAD, S_STREAM, S_DRAIN};
  assign last_fbeat = (fbeat_q == C_FBEAT_W'(C_LAST_FBEAT));

  // Results are only counted up to the target, so overshoot is ignored.
  assign arr_inc     = run_win && bus.arr_dataout_valid && !bus.abort && (out_cnt < cfg_out_q);
  assign out_reached = (out_cnt == cfg_out_q) ||
                       (arr_inc && ((out_cnt + C_CNT_WIDTH'(1)) == cfg_out_q));

  always_comb begin
    state_d = state_q;
    if (bus.abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   if (bus.start) state_d = S_CINIT;
        S_CINIT:  state_d = S_FLOAD;
        S_FLOAD:  if (filt_acc && last_fbeat) state_d = (pix_cnt == '0) ? S_DRAIN : S_STREAM;
        S_STREAM: if (img_acc && (pix_cnt == C_CNT_WIDTH'(1))) state_d = S_DRAIN;
        S_DRAIN:  if (out_reached) state_d = S_DONE;
        S_DONE:   state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      fbeat_q      <= '0;
      cfg_out_q    <= '0;
      count_init_q <= 1'b0;
      pipe_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      finit_q      <= '0;
      fdata_q      <= '0;
      idata_q      <= '0;
      ivld_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_init_q <= (state_d == S_CINIT);
      pipe_q       <= state_d inside {S_CINIT, S_FLOAD, S_STREAM, S_DRAIN};
      busy_q       <= (state_d != S_IDLE);
      done_q       <= (state_d == S_DONE);
      finit_q      <= {C_MAX_WINDOW_SIZE{filt_acc}};
      ivld_q       <= img_acc;
      if (filt_acc) fdata_q <= bus.filt_data;
      if (img_acc)  idata_q <= bus.img_data;
      if (start_go) begin
        cfg_out_q <= bus.cfg_num_out;
        fbeat_q   <= '0;
      end else if (filt_acc) begin
        fbeat_q <= last_fbeat ? '0 : fbeat_q + C_FBEAT_W'(1);
      end
    end
  end

  cnn_layer_accel_seq_counter #(.W(C_CNT_WIDTH)) u_pix_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (start_go),
    .load_val_i (bus.cfg_num_pix),
    .en_i       (img_acc),
    .up_i       (1'b0),
    .cnt_o      (pix_cnt)
  );

  cnn_layer_accel_seq_counter #(.W(C_CNT_WIDTH)) u_out_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (start_go),
    .load_val_i ('0),
    .en_i       (arr_inc),
    .up_i       (1'b1),
    .cnt_o      (out_cnt)
  );

`ifdef CNN_SEQ_PERF_CNT_EN
  logic stall_c;
  assign stall_c = (filt_rdy && !bus.filt_valid) || (img_rdy && !bus.img_valid);

  cnn_layer_accel_seq_counter #(.W(C_CNT_WIDTH)) u_stall_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (start_go),
    .load_val_i ('0),
    .en_i       (stall_c),
    .up_i       (1'b1),
    .cnt_o      (perf_stall_cycles)
  );

  cnn_layer_accel_seq_counter #(.W(C_CNT_WIDTH)) u_total_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (start_go),
    .load_val_i ('0),
    .en_i       (state_q != S_IDLE),
    .up_i       (1'b1),
    .cnt_o      (perf_total_cycles)
  );
`endif

  assign bus.filt_ready       = filt_rdy;
  assign bus.img_ready        = img_rdy;
  assign bus.count_init       = count_init_q;
  assign bus.pipeline_active  = pipe_q;
  assign bus.i_filter_init    = finit_q;
  assign bus.i_filter_datain  = fdata_q;
  assign bus.i_img_datain     = idata_q;
  assign bus.img_datain_valid = ivld_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;

endmodule

// File: tb/tb_cnn_layer_accel_conv_seq_ctrl.sv
// Randomized bench for the conv-array sequencer against a job-level reference model.
// Perf counter checks are included when CNN_SEQ_PERF_CNT_EN is defined.
module tb_cnn_layer_accel_conv_seq_ctrl;
  import cnn_layer_accel_seq_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cnn_layer_accel_conv_seq_ctrl_if bus ();

`ifdef CNN_SEQ_PERF_CNT_EN
  logic [C_CNT_WIDTH-1:0] perf_stall_cycles;
  logic [C_CNT_WIDTH-1:0] perf_total_cycles;
`endif

  cnn_layer_accel_conv_seq_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef CNN_SEQ_PERF_CNT_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_total_cycles (perf_total_cycles)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Job model: mode 0 idle, 1 count-init cycle, 2 working, 3 completion cycle.
  int m_mode = 0;
  int m_fl = 0;   // filter beats still owed
  int m_pl = 0;   // image beats still owed
  int m_res = 0;  // results counted so far
  int m_tgt = 0;  // results required
  int e_total = 0;
  int e_stall = 0;
  logic                    e_finit = 1'b0;
  logic                    e_ivld  = 1'b0;
  logic                    e_busy  = 1'b0;
  logic                    e_pipe  = 1'b0;
  logic                    e_cinit = 1'b0;
  logic                    e_done  = 1'b0;
  logic [C_FILT_BUS_W-1:0] e_fdata = '0;
  logic [C_IMG_BUS_W-1:0]  e_idata = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_inputs(input logic st, input logic ab, input logic fv, input logic iv,
                            input logic arr);
    logic [63:0] r;
    bus.start = st;
    bus.abort = ab;
    bus.filt_valid = fv;
    bus.img_valid = iv;
    bus.arr_dataout_valid = arr;
    r = {$urandom, $urandom};
    bus.filt_data = r[C_FILT_BUS_W-1:0];
    r = {$urandom, $urandom};
    bus.img_data = r[C_IMG_BUS_W-1:0];
  endtask

  // Check this cycle's outputs, then advance the model across the next edge.
  task automatic tick();
    logic frdy, irdy, drain, fa, ia;
    logic [C_MAX_WINDOW_SIZE-1:0] fi;
    @(negedge clk);
    frdy = (m_mode == 2) && (m_fl > 0);
    irdy = (m_mode == 2) && (m_fl == 0) && (m_pl > 0);
    fi = e_finit ? '1 : '0;
    chk("filt_ready", 64'(bus.filt_ready), 64'(frdy));
    chk("img_ready", 64'(bus.img_ready), 64'(irdy));
    chk("busy", 64'(bus.busy), 64'(e_busy));
    chk("pipeline_active", 64'(bus.pipeline_active), 64'(e_pipe));
    chk("count_init", 64'(bus.count_init), 64'(e_cinit));
    chk("done", 64'(bus.done), 64'(e_done));
    chk("i_filter_init", 64'(bus.i_filter_init), 64'(fi));
    chk("i_filter_datain", 64'(bus.i_filter_datain), 64'(e_fdata));
    chk("img_datain_valid", 64'(bus.img_datain_valid), 64'(e_ivld));
    chk("i_img_datain", 64'(bus.i_img_datain), 64'(e_idata));
`ifdef CNN_SEQ_PERF_CNT_EN
    chk("perf_total", 64'(perf_total_cycles), 64'(e_total));
    chk("perf_stall", 64'(perf_stall_cycles), 64'(e_stall));
`endif
    fa = frdy && bus.filt_valid && !bus.abort;
    ia = irdy && bus.img_valid && !bus.abort;
    e_finit = 1'b0;
    e_ivld = 1'b0;
    if (!rst) begin
      m_mode = 0; m_fl = 0; m_pl = 0; m_res = 0; m_tgt = 0;
      e_fdata = '0; e_idata = '0; e_total = 0; e_stall = 0;
    end else begin
      if (m_mode != 0) begin
        e_total++;
        if ((frdy && !bus.filt_valid) || (irdy && !bus.img_valid)) e_stall++;
      end
      if (m_mode != 0 && bus.abort) begin
        m_mode = 0;
      end else begin
        if ((m_mode == 1 || m_mode == 2) && bus.arr_dataout_valid && m_res < m_tgt) m_res++;
        case (m_mode)
          0: if (bus.start) begin
            m_mode = 1; m_fl = C_MAX_WINDOW_SIZE;
            m_pl = int'(bus.cfg_num_pix); m_tgt = int'(bus.cfg_num_out); m_res = 0;
            e_total = 0; e_stall = 0;
          end
          1: m_mode = 2;
          2: begin
            drain = (m_fl == 0) && (m_pl == 0);
            if (fa) begin m_fl--; e_finit = 1'b1; e_fdata = bus.filt_data; end
            if (ia) begin m_pl--; e_ivld = 1'b1; e_idata = bus.img_data; end
            if (drain && m_res >= m_tgt) m_mode = 3;
          end
          default: m_mode = 0;
        endcase
      end
    end
    e_busy  = (m_mode != 0);
    e_pipe  = (m_mode == 1) || (m_mode == 2);
    e_cinit = (m_mode == 1);
    e_done  = (m_mode == 3);
    @(posedge clk);
    #1;
  endtask

  // vmode: 0 valids high, 1 image valid every other cycle, 2 random, 3 three image stalls.
  // disturb: 0 none, 1 abort after 2nd filter beat, 2 start mid-stream, 3 reset mid-stream.
  task automatic run_job(input int npix, input int nout, input int vmode, input int disturb);
    int budget;
    int stalls;
    logic fv, iv, st, ab, done_dist;
    bus.cfg_num_pix = C_CNT_WIDTH'(npix);
    bus.cfg_num_out = C_CNT_WIDTH'(nout);
    set_inputs(1'b1, 1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
    tick();
    budget = 0;
    stalls = 0;
    done_dist = 1'b0;
    while (m_mode != 0 && budget < 500) begin
      rst = 1'b1;
      st = 1'b0;
      ab = 1'b0;
      fv = 1'b1;
      iv = 1'b1;
      case (vmode)
        1: iv = ((budget % 2) == 1);
        2: begin fv = ($urandom_range(0, 99) < 60); iv = ($urandom_range(0, 99) < 60); end
        3: if (m_mode == 2 && m_fl == 0 && m_pl > 0 && stalls < 3) begin iv = 1'b0; stalls++; end
        default: ;
      endcase
      if (!done_dist) begin
        if (disturb == 1 && m_mode == 2 && m_fl == C_MAX_WINDOW_SIZE - 2) begin
          ab = 1'b1; done_dist = 1'b1;
        end else if (disturb >= 2 && m_mode == 2 && m_fl == 0 && m_pl > 0 && m_pl < npix) begin
          done_dist = 1'b1;
          if (disturb == 2) begin
            st = 1'b1;
            bus.cfg_num_pix = C_CNT_WIDTH'(3);
            bus.cfg_num_out = C_CNT_WIDTH'($urandom_range(0, 2));
          end else begin
            rst = 1'b0;
          end
        end
      end
      set_inputs(st, ab, fv, iv, 1'($urandom_range(0, 99) < 35));
      tick();
      budget++;
    end
    chk("job_terminates", 64'(budget < 500), 64'(1));
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_inputs(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
      tick();
    end
  endtask

  initial begin
    rst = 1'b0;
    bus.cfg_num_pix = '0;
    bus.cfg_num_out = '0;
    set_inputs(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    tick();
    tick();
    rst = 1'b1;
    set_inputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    run_job(8, 6, 0, 0);
    run_job(8, 6, 1, 0);
    run_job(0, 0, 0, 0);
    run_job(8, 6, 0, 1);
    run_job(8, 6, 0, 0);
    run_job(8, 6, 0, 2);
    run_job(8, 6, 0, 3);
    run_job(8, 6, 3, 0);
    run_job(4, 1, 0, 0);
    run_job(0, 3, 2, 0);
    for (int j = 0; j < 8; j++) begin
      run_job(int'($urandom_range(0, 12)), int'($urandom_range(0, 8)), 2,
              int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
